// File: rtl/sccb_config_sequencer.sv
// sccb_config_sequencer: walks a multi-profile register table from an external
// synchronous ROM and issues one SCCB register write per table entry.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start_i      one-cycle pulse that begins a sequence (honoured only in IDLE)
//   profile_i    table select, latched on start
//   rom_addr_o   {profile, index} to the config ROM (data returns one cycle later)
//   rom_data_i   {reg_addr[15:8], reg_value[7:0]} from the ROM
//   cmd_valid_o  write request to the SCCB master
//   cmd_ready_i  master accepts the request
//   cmd_reg_o    register address of the request
//   cmd_val_o    register value of the request
//   cmd_done_i   one-cycle pulse when the SCCB transaction completes
//   cmd_nack_i   qualifies cmd_done_i; high means the slave NACKed
//   busy_o       high in every state except IDLE, DONE and ERROR
//   done_o       sticky, set when the table ends
//   error_o      sticky, set when NACK retries are exhausted
//   entry_cnt_o  number of successfully completed writes (saturating)
module sccb_config_sequencer #(
    parameter int          IDX_W        = 8,
    parameter int          PROF_W       = 2,
    parameter logic [15:0] END_CODE     = 16'hFFFF,
    parameter logic [15:0] DELAY_CODE   = 16'hFFF0,
    parameter int          DELAY_CYCLES = 1_000_000,
    parameter int          MAX_RETRY    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [PROF_W-1:0]       profile_i,
    output logic [PROF_W+IDX_W-1:0] rom_addr_o,
    input  logic [15:0]             rom_data_i,
    output logic                    cmd_valid_o,
    input  logic                    cmd_ready_i,
    output logic [7:0]              cmd_reg_o,
    output logic [7:0]              cmd_val_o,
    input  logic                    cmd_done_i,
    input  logic                    cmd_nack_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [IDX_W:0]          entry_cnt_o
);

    // Delay counter holds DELAY_CYCLES-1 down to 0; sized so DELAY_CYCLES=1 still works.
    localparam int DLY_W = $clog2(DELAY_CYCLES + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DELAY_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, SEND, WAIT_ACK, DELAY, DONE, ERROR
    } state_e;

    state_e              state_q, state_d;
    logic [PROF_W-1:0]   prof_q, prof_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          reg_q, reg_d;
    logic [7:0]          val_q, val_d;
    logic [RTY_W-1:0]    retry_q, retry_d;
    logic [DLY_W-1:0]    dly_q, dly_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [IDX_W:0]      cnt_q, cnt_d;
    logic                adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prof_q  <= '0;
            idx_q   <= '0;
            reg_q   <= '0;
            val_q   <= '0;
            retry_q <= '0;
            dly_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prof_q  <= prof_d;
            idx_q   <= idx_d;
            reg_q   <= reg_d;
            val_q   <= val_d;
            retry_q <= retry_d;
            dly_q   <= dly_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prof_d  = prof_q;
        idx_d   = idx_q;
        reg_d   = reg_q;
        val_d   = val_q;
        retry_d = retry_q;
        dly_d   = dly_q;
        done_d  = done_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    prof_d  = profile_i;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (rom_data_i == END_CODE) begin
                    state_d = DONE;
                end else if (rom_data_i == DELAY_CODE) begin
                    dly_d   = DLY_LOAD;
                    state_d = DELAY;
                end else begin
                    reg_d   = rom_data_i[15:8];
                    val_d   = rom_data_i[7:0];
                    retry_d = '0;
                    state_d = SEND;
                end
            end
            SEND: state_d = cmd_ready_i ? WAIT_ACK : SEND;
            WAIT_ACK: begin
                if (cmd_done_i) begin
                    if (!cmd_nack_i) begin
                        cnt_d = cnt_q + (IDX_W + 1)'(cnt_q != '1);
                        adv   = 1'b1;
                    end else if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = SEND;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            DELAY: begin
                if (dly_q == '0) adv = 1'b1;
                else dly_d = dly_q - DLY_W'(1);
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The last entry of a profile ends the table implicitly instead of
        // wrapping the index into the neighbouring profile.
        if (adv) begin
            if (idx_q == '1) begin
                state_d = DONE;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = FETCH;
            end
        end
        // Flags rise together with entry into DONE/ERROR so done is visible
        // in the DONE cycle itself.
        if (state_d == DONE) done_d = 1'b1;
        if (state_d == ERROR) err_d = 1'b1;
    end

    // Decoded straight from the state register so an asynchronous reset
    // withdraws the request immediately.
    assign cmd_valid_o = (state_q == SEND);
    assign busy_o      = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign rom_addr_o  = {prof_q, idx_q};
    assign cmd_reg_o   = reg_q;
    assign cmd_val_o   = val_q;
    assign done_o      = done_q;
    assign error_o     = err_q;
    assign entry_cnt_o = cnt_q;

endmodule
